cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory bridge port between ICache refills,
// DCache refills and DCache writebacks, one transaction in flight at a time.
module cache_mem_arbiter #(
    parameter  int STARVE_LIMIT = 4,
    localparam int CW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ic_req_valid,
    input  logic [31:0]   ic_req_addr,
    output logic          ic_req_ready,
    output logic          ic_resp_valid,
    output logic [127:0]  ic_resp_line,
    input  logic          ic_resp_ready,
    input  logic          dc_rd_valid,
    input  logic [31:0]   dc_rd_addr,
    output logic          dc_rd_ready,
    input  logic          dc_wb_valid,
    input  logic [31:0]   dc_wb_addr,
    input  logic [127:0]  dc_wb_line,
    output logic          dc_wb_ready,
    output logic          dc_resp_valid,
    output logic [127:0]  dc_resp_line,
    input  logic          dc_resp_ready,
    output logic          dc_wb_done,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [31:0]   mem_req_addr,
    output logic [127:0]  mem_req_wdata,
    output logic          mem_req_we,
    input  logic          mem_resp_valid,
    input  logic [127:0]  mem_resp_line,
    output logic          mem_resp_ready,
    input  logic          mem_wdone,
    output logic [2:0]    dbg_state_o,
    output logic [CW-1:0] dbg_starve_o
);
    // Handshakes: a transfer occurs on a posedge where valid and ready are both
    // high; the source holds valid (and its payload) stable until it sees ready,
    // and ready never depends on anything but valid and the arbiter state.

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_WAIT_WR, S_RESP} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DCR, OWN_DCW} owner_e;

    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF0;

    state_e        state_q,   state_d;
    owner_e        owner_q,   owner_d;
    logic [31:0]   addr_q,    addr_d;
    logic [127:0]  wdata_q,   wdata_d;
    logic [127:0]  line_q,    line_d;
    logic          we_q,      we_d;
    logic [CW-1:0] starve_q,  starve_d;
    logic          wb_done_q, wb_done_d;

    logic          starved;
    logic [CW-1:0] starve_inc;

    assign starved    = (starve_q == CW'(STARVE_LIMIT));
    assign starve_inc = starved ? starve_q : starve_q + CW'(1);

    // Next-state, grant selection and all bus outputs; everything is forced
    // quiet while rst is low so nothing is granted or forwarded during reset.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        line_d         = line_q;
        we_d           = we_q;
        starve_d       = starve_q;
        wb_done_d      = 1'b0;
        ic_req_ready   = 1'b0;
        dc_rd_ready    = 1'b0;
        dc_wb_ready    = 1'b0;
        ic_resp_valid  = 1'b0;
        ic_resp_line   = '0;
        dc_resp_valid  = 1'b0;
        dc_resp_line   = '0;
        mem_req_valid  = 1'b0;
        mem_req_addr   = '0;
        mem_req_wdata  = '0;
        mem_req_we     = 1'b0;
        mem_resp_ready = 1'b0;
        if (rst) begin
            case (state_q)
                S_IDLE: begin
                    // ICache wins if it is alone or has been passed over too often.
                    if (ic_req_valid && (starved || (!dc_wb_valid && !dc_rd_valid))) begin
                        ic_req_ready = 1'b1;
                        owner_d      = OWN_IC;
                        addr_d       = ic_req_addr & LINE_MASK;
                        wdata_d      = '0;
                        we_d         = 1'b0;
                        starve_d     = '0;
                        state_d      = S_ISSUE;
                    end else if (dc_wb_valid) begin
                        dc_wb_ready  = 1'b1;
                        owner_d      = OWN_DCW;
                        addr_d       = dc_wb_addr & LINE_MASK;
                        wdata_d      = dc_wb_line;
                        we_d         = 1'b1;
                        starve_d     = ic_req_valid ? starve_inc : '0;
                        state_d      = S_ISSUE;
                    end else if (dc_rd_valid) begin
                        dc_rd_ready  = 1'b1;
                        owner_d      = OWN_DCR;
                        addr_d       = dc_rd_addr & LINE_MASK;
                        wdata_d      = '0;
                        we_d         = 1'b0;
                        starve_d     = ic_req_valid ? starve_inc : '0;
                        state_d      = S_ISSUE;
                    end else begin
                        starve_d     = '0;
                    end
                end
                S_ISSUE: begin
                    mem_req_valid = 1'b1;
                    mem_req_addr  = addr_q;
                    mem_req_wdata = wdata_q;
                    mem_req_we    = we_q;
                    if (mem_req_ready) begin
                        state_d = we_q ? S_WAIT_WR : S_WAIT_RD;
                    end
                end
                S_WAIT_RD: begin
                    mem_resp_ready = 1'b1;
                    if (mem_resp_valid) begin
                        line_d  = mem_resp_line;
                        state_d = S_RESP;
                    end
                end
                S_WAIT_WR: begin
                    if (mem_wdone) begin
                        wb_done_d = 1'b1;
                        owner_d   = OWN_NONE;
                        state_d   = S_IDLE;
                    end
                end
                S_RESP: begin
                    if (owner_q == OWN_IC) begin
                        ic_resp_valid = 1'b1;
                        ic_resp_line  = line_q;
                        if (ic_resp_ready) begin
                            owner_d = OWN_NONE;
                            state_d = S_IDLE;
                        end
                    end else if (owner_q == OWN_DCR) begin
                        dc_resp_valid = 1'b1;
                        dc_resp_line  = line_q;
                        if (dc_resp_ready) begin
                            owner_d = OWN_NONE;
                            state_d = S_IDLE;
                        end
                    end else begin
                        owner_d = OWN_NONE;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and latched transaction registers; reset drops any in-flight work.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_NONE;
            addr_q    <= '0;
            wdata_q   <= '0;
            line_q    <= '0;
            we_q      <= 1'b0;
            starve_q  <= '0;
            wb_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            line_q    <= line_d;
            we_q      <= we_d;
            starve_q  <= starve_d;
            wb_done_q <= wb_done_d;
        end
    end

    assign dc_wb_done   = wb_done_q & rst;
    assign dbg_state_o  = state_q;
    assign dbg_starve_o = starve_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: randomized requesters and bridge against a
// transaction-level model of grant priority, starvation and data flow.
module tb_cache_mem_arbiter;
    localparam int LIMIT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ic_req_valid = 1'b0;
    logic [31:0]  ic_req_addr = '0;
    logic         ic_req_ready;
    logic         ic_resp_valid;
    logic [127:0] ic_resp_line;
    logic         ic_resp_ready = 1'b0;
    logic         dc_rd_valid = 1'b0;
    logic [31:0]  dc_rd_addr = '0;
    logic         dc_rd_ready;
    logic         dc_wb_valid = 1'b0;
    logic [31:0]  dc_wb_addr = '0;
    logic [127:0] dc_wb_line = '0;
    logic         dc_wb_ready;
    logic         dc_resp_valid;
    logic [127:0] dc_resp_line;
    logic         dc_resp_ready = 1'b0;
    logic         dc_wb_done;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_wdata;
    logic         mem_req_we;
    logic         mem_resp_valid = 1'b0;
    logic [127:0] mem_resp_line = '0;
    logic         mem_resp_ready;
    logic         mem_wdone = 1'b0;
    logic [2:0]   dbg_state;
    logic [2:0]   dbg_starve;

    int n_cmp = 0;
    int n_bad = 0;
    int m_starve = 0;
    bit wb_done_due = 1'b0;
    logic [127:0] exp_q[$];

    cache_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_line(ic_resp_line), .ic_resp_ready(ic_resp_ready),
        .dc_rd_valid(dc_rd_valid), .dc_rd_addr(dc_rd_addr), .dc_rd_ready(dc_rd_ready),
        .dc_wb_valid(dc_wb_valid), .dc_wb_addr(dc_wb_addr), .dc_wb_line(dc_wb_line),
        .dc_wb_ready(dc_wb_ready),
        .dc_resp_valid(dc_resp_valid), .dc_resp_line(dc_resp_line), .dc_resp_ready(dc_resp_ready),
        .dc_wb_done(dc_wb_done),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_we(mem_req_we),
        .mem_resp_valid(mem_resp_valid), .mem_resp_line(mem_resp_line),
        .mem_resp_ready(mem_resp_ready), .mem_wdone(mem_wdone),
        .dbg_state_o(dbg_state), .dbg_starve_o(dbg_starve)
    );

    // clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not end, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Winner by the priority rule: 0 = IC, 1 = DCache read, 2 = DCache writeback.
    function automatic int pick(input bit ic, input bit dcr, input bit dcw, input int starve);
        if (ic && starve == LIMIT) return 0;
        if (dcw) return 2;
        if (dcr) return 1;
        if (ic) return 0;
        return -1;
    endfunction

    function automatic logic [2:0] onehot(input int w);
        case (w)
            0:       return 3'b100;
            1:       return 3'b010;
            2:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, ".ctrl"}, 128'({ic_req_ready, dc_rd_ready, dc_wb_ready, ic_resp_valid,
              dc_resp_valid, mem_req_valid, mem_req_we, mem_resp_ready}), 128'(0));
        check({tag, ".addr"}, 128'(mem_req_addr), 128'(0));
        check({tag, ".data"}, mem_req_wdata | ic_resp_line | dc_resp_line, 128'(0));
    endtask

    task automatic check_busy(input string tag);
        check({tag, ".ready"}, 128'({ic_req_ready, dc_rd_ready, dc_wb_ready}), 128'(0));
    endtask

    task automatic raise_random();
        if (!ic_req_valid && $urandom_range(0, 1) == 1) begin
            ic_req_valid = 1'b1;
            ic_req_addr  = $urandom;
        end
        if (!dc_rd_valid && $urandom_range(0, 1) == 1) begin
            dc_rd_valid = 1'b1;
            dc_rd_addr  = $urandom;
        end
        if (!dc_wb_valid && $urandom_range(0, 1) == 1) begin
            dc_wb_valid = 1'b1;
            dc_wb_addr  = $urandom;
            dc_wb_line  = rand_line();
        end
    endtask

    // Idle cycles with no requester: everything must stay silent.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            mem_wdone = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("idle.wb_done", 128'(dc_wb_done), 128'(wb_done_due));
            wb_done_due = 1'b0;
            check_quiet("idle");
            m_starve = 0;
            step();
        end
        mem_wdone = 1'b0;
    endtask

    // One arbitration plus the full memory transaction it starts.
    task automatic run_txn(input int resp_hold, input bit refill_dcr, input bit rand_new,
                           input bit use_fixed, input logic [127:0] fixed_line);
        int w;
        int d;
        logic [31:0] ea;
        logic [127:0] ewd;
        logic ewe;
        logic [127:0] line;
        @(negedge clk);
        check("arb.wb_done", 128'(dc_wb_done), 128'(wb_done_due));
        wb_done_due = 1'b0;
        check("arb.starve", 128'(dbg_starve), 128'(m_starve));
        w = pick(ic_req_valid, dc_rd_valid, dc_wb_valid, m_starve);
        check("arb.grant", 128'({ic_req_ready, dc_rd_ready, dc_wb_ready}), 128'(onehot(w)));
        case (w)
            0:       ea = ic_req_addr;
            1:       ea = dc_rd_addr;
            default: ea = dc_wb_addr;
        endcase
        ea  = {ea[31:4], 4'h0};
        ewe = (w == 2);
        ewd = ewe ? dc_wb_line : '0;
        if (w == 0) m_starve = 0;
        else if (ic_req_valid) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
        else m_starve = 0;
        step();
        case (w)
            0:       ic_req_valid = 1'b0;
            1:       dc_rd_valid = 1'b0;
            default: dc_wb_valid = 1'b0;
        endcase
        if (refill_dcr && w == 1) begin
            dc_rd_valid = 1'b1;
            dc_rd_addr  = $urandom;
        end
        if (rand_new) raise_random();
        d = $urandom_range(0, 3);
        for (int i = 0; i <= d; i++) begin
            mem_req_ready = (i == d);
            mem_wdone     = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("issue.valid", 128'(mem_req_valid), 128'(1));
            check("issue.addr", 128'(mem_req_addr), 128'(ea));
            check("issue.we", 128'(mem_req_we), 128'(ewe));
            check("issue.wdata", mem_req_wdata, ewd);
            check("issue.wb_done", 128'(dc_wb_done), 128'(0));
            check_busy("issue");
            step();
        end
        mem_req_ready = 1'b0;
        mem_wdone     = 1'b0;
        if (ewe) begin
            d = $urandom_range(0, 3);
            for (int i = 0; i <= d; i++) begin
                mem_wdone      = (i == d);
                mem_resp_valid = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("wr.resp_ready", 128'(mem_resp_ready), 128'(0));
                check("wr.req_valid", 128'(mem_req_valid), 128'(0));
                check("wr.wb_done", 128'(dc_wb_done), 128'(0));
                check_busy("wr");
                step();
            end
            mem_wdone      = 1'b0;
            mem_resp_valid = 1'b0;
            wb_done_due    = 1'b1;
        end else begin
            d = $urandom_range(0, 3);
            for (int i = 0; i <= d; i++) begin
                mem_resp_valid = (i == d);
                if (i == d) begin
                    line = use_fixed ? fixed_line : rand_line();
                    mem_resp_line = line;
                    exp_q.push_back(line);
                end else begin
                    mem_resp_line = rand_line();
                end
                @(negedge clk);
                check("rd.resp_ready", 128'(mem_resp_ready), 128'(1));
                check("rd.early", 128'({ic_resp_valid, dc_resp_valid}), 128'(0));
                check_busy("rd");
                step();
            end
            mem_resp_valid = 1'b0;
            mem_resp_line  = rand_line();
            for (int i = 0; i <= resp_hold; i++) begin
                ic_resp_ready = (w == 0) ? (i == resp_hold) : 1'($urandom_range(0, 1));
                dc_resp_ready = (w == 1) ? (i == resp_hold) : 1'($urandom_range(0, 1));
                mem_wdone     = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("resp.valid", 128'({ic_resp_valid, dc_resp_valid}),
                      128'((w == 0) ? 2'b10 : 2'b01));
                check("resp.line", (w == 0) ? ic_resp_line : dc_resp_line, exp_q[0]);
                check("resp.other", (w == 0) ? dc_resp_line : ic_resp_line, 128'(0));
                check("resp.mem", 128'({mem_req_valid, mem_resp_ready, dc_wb_done}), 128'(0));
                check_busy("resp");
                step();
            end
            ic_resp_ready = 1'b0;
            dc_resp_ready = 1'b0;
            mem_wdone     = 1'b0;
            void'(exp_q.pop_front());
        end
    endtask

    task automatic drain();
        while (ic_req_valid || dc_rd_valid || dc_wb_valid) begin
            run_txn($urandom_range(0, 2), 1'b0, 1'b0, 1'b0, '0);
        end
    endtask

    // stimulus sequence and final report
    initial begin
        // reset with requests and bridge activity present: nothing may leak out
        ic_req_valid   = 1'b1;
        ic_req_addr    = 32'h1234_5678;
        dc_wb_valid    = 1'b1;
        mem_resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet("reset");
            check("reset.wb_done", 128'(dc_wb_done), 128'(0));
        end
        check("reset.starve", 128'(dbg_starve), 128'(0));
        step();
        rst            = 1'b1;
        ic_req_valid   = 1'b0;
        dc_wb_valid    = 1'b0;
        mem_resp_valid = 1'b0;
        idle_cycles(2);

        // ICache refill of 0x1C00_0024, response held back for 10 cycles
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h1C00_0024;
        run_txn(10, 1'b0, 1'b1, 1'b1, {4{32'hAAAA_AAAA}});
        drain();
        idle_cycles(1);

        // all three requesters at once: writeback, then read, then ICache
        ic_req_valid = 1'b1;
        ic_req_addr  = $urandom;
        dc_rd_valid  = 1'b1;
        dc_rd_addr   = $urandom;
        dc_wb_valid  = 1'b1;
        dc_wb_addr   = $urandom;
        dc_wb_line   = rand_line();
        for (int k = 0; k < 3; k++) run_txn($urandom_range(0, 2), 1'b0, 1'b0, 1'b0, '0);
        idle_cycles(1);

        // back-to-back DCache reads while ICache waits
        ic_req_valid = 1'b1;
        ic_req_addr  = $urandom;
        dc_rd_valid  = 1'b1;
        dc_rd_addr   = $urandom;
        for (int k = 0; k < LIMIT + 1; k++) run_txn(0, 1'b1, 1'b0, 1'b0, '0);
        drain();
        idle_cycles(1);

        // randomized traffic
        for (int k = 0; k < 60; k++) begin
            if (!(ic_req_valid || dc_rd_valid || dc_wb_valid)) begin
                idle_cycles($urandom_range(1, 2));
                for (int t = 0; t < 20 && !(ic_req_valid || dc_rd_valid || dc_wb_valid); t++)
                    raise_random();
                if (!(ic_req_valid || dc_rd_valid || dc_wb_valid)) begin
                    ic_req_valid = 1'b1;
                    ic_req_addr  = $urandom;
                end
            end
            run_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, 1'b0, '0);
        end
        drain();
        idle_cycles(1);

        // reset while waiting for read data; the late line must be dropped
        ic_req_valid = 1'b1;
        ic_req_addr  = $urandom;
        @(negedge clk);
        check("rst48.grant", 128'(ic_req_ready), 128'(1));
        step();
        ic_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        check("rst48.issue", 128'(mem_req_valid), 128'(1));
        step();
        mem_req_ready = 1'b0;
        @(negedge clk);
        check("rst48.wait", 128'(mem_resp_ready), 128'(1));
        step();
        rst = 1'b0;
        @(negedge clk);
        check_quiet("rst48.during");
        step();
        rst            = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_line  = rand_line();
        m_starve       = 0;
        @(negedge clk);
        check_quiet("rst48.after");
        check("rst48.starve", 128'(dbg_starve), 128'(0));
        step();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check_quiet("rst48.late");
        check("rst48.wb_done", 128'(dc_wb_done), 128'(0));
        step();

        // a fresh transaction after reset still works
        ic_req_valid = 1'b1;
        ic_req_addr  = $urandom;
        run_txn(1, 1'b0, 1'b0, 1'b0, '0);
        idle_cycles(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
